// File: rtl/dmem_arbiter_pkg.sv
// Shared types and memop constants for the data-memory arbiter and the
// CPU/memory blocks that speak the same memop encoding.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_align_chk.sv
// Flags halfword/word accesses whose address is not naturally aligned.
module dmem_align_chk
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  always_comb begin
    o_misaligned = 1'b0;
    case (i_op)
      OP_H, OP_HU: o_misaligned = i_addr_lo[0];
      OP_W:        o_misaligned = |i_addr_lo;
      default:     o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Every grant runs IDLE -> ACCESS -> RESP, so latency is fixed at two cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_op,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_op,
  output logic        mem_we,
  output logic        mem_rdclk,
  output logic        mem_wrclk,
  input  logic [31:0] mem_dataout,
  output logic        busy,
  output logic [15:0] cnt_m0,
  output logic [15:0] cnt_m1
);

  // state  | meaning
  // IDLE   | no access in flight; winner latched on the cycle a req is seen
  // ACCESS | memory driven from the latched request; write lands mid-cycle
  // RESP   | one-cycle ready/err pulse to the granted port, read data valid

  arb_state_t  r_state;
  logic        r_ptr;
  logic        r_gnt;
  logic        r_mis;
  logic        r_mem_we;
  mem_req_t    r_req;
  logic [15:0] r_cnt_m0;
  logic [15:0] r_cnt_m1;

  logic        w_win;
  logic        w_mis;
  logic        w_resp;
  mem_req_t    w_win_req;

  // preferred port wins only on a tie; a lone requester always wins
  assign w_win     = (m0_req & m1_req) ? r_ptr : m1_req;
  assign w_win_req = w_win ? {m1_we, m1_op, m1_addr, m1_wdata}
                           : {m0_we, m0_op, m0_addr, m0_wdata};

  dmem_align_chk u_align_chk (
    .i_op         (w_win_req.op),
    .i_addr_lo    (w_win_req.addr[1:0]),
    .o_misaligned (w_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 1'b0;
      r_gnt    <= 1'b0;
      r_mis    <= 1'b0;
      r_mem_we <= 1'b0;
      r_req    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_req | m1_req) begin
            r_req    <= w_win_req;
            r_gnt    <= w_win;
            r_mis    <= w_mis;
            r_ptr    <= ~w_win;
            r_mem_we <= w_win_req.we & ~w_mis;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          r_state  <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: begin
          r_mem_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_m0 <= '0;
      r_cnt_m1 <= '0;
    end else if (r_state == ST_RESP) begin
      if (!r_gnt && r_cnt_m0 != 16'hFFFF) r_cnt_m0 <= r_cnt_m0 + 16'd1;
      if (r_gnt && r_cnt_m1 != 16'hFFFF)  r_cnt_m1 <= r_cnt_m1 + 16'd1;
    end
  end

  // reset in RESP must swallow the pulse that is already on the outputs
  assign w_resp   = (r_state == ST_RESP) & ~reset;
  assign m0_ready = w_resp & ~r_gnt;
  assign m1_ready = w_resp & r_gnt;
  assign m0_err   = m0_ready & r_mis;
  assign m1_err   = m1_ready & r_mis;
  assign m0_rdata = (m0_ready & ~r_mis) ? mem_dataout : 32'd0;
  assign m1_rdata = (m1_ready & ~r_mis) ? mem_dataout : 32'd0;

  assign mem_addr   = r_req.addr;
  assign mem_datain = r_req.wdata;
  assign mem_op     = r_req.op;
  assign mem_we     = r_mem_we;
  assign mem_rdclk  = clk;
  assign mem_wrclk  = ~clk;

  assign busy   = (r_state != ST_IDLE);
  assign cnt_m0 = r_cnt_m0;
  assign cnt_m1 = r_cnt_m1;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide, for each requester port m0 (CPU) and m1 (debug/loader): mN_req in 1; mN_we in 1; mN_op in 3 (memop encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu); mN_addr in 32; mN_wdata in 32; mN_ready out 1; mN_err out 1; mN_rdata out 32.
REQ-004 SHALL drive the shared memory through: mem_addr out 32; mem_datain out 32; mem_op out 3; mem_we out 1; mem_rdclk out 1; mem_wrclk out 1; mem_dataout in 32, registered on mem_rdclk rising edge.
REQ-005 SHALL output: busy out 1; cnt_m0 out 16; cnt_m1 out 16 (completed-grant counters).

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-007 In IDLE with any req high, SHALL latch the winner's we/op/addr/wdata and go to ACCESS next cycle; with no req, SHALL stay in IDLE.
REQ-008 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred port; on simultaneous req the preferred port wins; the pointer SHALL move to the other port after every grant.
REQ-009 In ACCESS, SHALL drive mem_* from the latched request; mem_we = latched we AND NOT misaligned; then go to RESP.
REQ-010 mem_rdclk SHALL equal clk; mem_wrclk SHALL equal inverted clk, so a write completes within ACCESS.
REQ-011 In RESP, SHALL pulse the granted port's ready for exactly one cycle, present mem_dataout on its rdata in that cycle (reads), then return to IDLE.
REQ-012 Fixed latency: req sampled in IDLE at cycle T -> ready high in cycle T+2; next grant no earlier than T+3.
REQ-013 Misaligned access (h/hu with addr[0]=1; w with addr[1:0]!=0) SHALL assert err together with ready, suppress mem_we, and return rdata 0.
REQ-014 Outside RESP, ready/err SHALL be 0 and rdata SHALL be 0 for both ports; the non-granted port SHALL never see ready.
REQ-015 Requesters SHALL hold req and fields stable until ready; req changes after latching SHALL not affect the access in flight.
REQ-016 mem_we SHALL be 0 in IDLE and RESP; mem_addr/op/datain SHALL hold the last latched values while not in ACCESS.
REQ-017 cnt_mN SHALL increment on each RESP cycle for port N (including err) and saturate at 0xFFFF.
REQ-018 busy SHALL be high in ACCESS and RESP.

Reset
REQ-019 On reset: state IDLE, pointer = m0, counters 0, mem_we 0, mem_addr/op/datain 0, all ready/err/rdata 0, busy 0.
REQ-020 Reset asserted in ACCESS or RESP SHALL abandon the access: no ready pulse, no counter increment; a write already issued in ACCESS is not rolled back.

Structure
REQ-021 State encoding and memop constants (OP_B, OP_H, OP_W, OP_BU, OP_HU) SHALL reside in a shared package used by CPU and memory blocks.
REQ-022 The misalignment check SHALL be a sub-module dmem_align_chk (op, addr[1:0] -> misaligned).

Verification
REQ-023 m0 lw addr 0x100 alone, memory word 0xDEADBEEF -> m0_ready high 2 cycles after req, m0_rdata 0xDEADBEEF, cnt_m0 = 1.
REQ-024 m0 and m1 req in same IDLE cycle after reset -> m0 served first, m1 ready 3 cycles later; repeat -> m1 served first.
REQ-025 m1 sb 0x12 at addr 0x203, then m1 lbu 0x203 -> rdata 0x00000012; other bytes of word 0x200 unchanged.
REQ-026 m0 sw addr 0x102 -> m0_ready and m0_err high together, mem_we never high, memory at 0x100 unchanged.
REQ-027 Reset pulsed in ACCESS of a read -> no ready on either port, counters 0, FSM IDLE next cycle.
REQ-028 Force cnt_m0 to 0xFFFF, one more m0 access -> cnt_m0 remains 0xFFFF.
